hdmi_packet_scheduler: RTL
==========================

Name: hdmi_packet_scheduler

Overview:
- Pixel-clock packet arbiter for the HDMI data-island path and the successor to the fixed two-channel picker.
- Buffers incoming audio sample frames in a parametrised FIFO and supports 2-channel (layout 0) or 8-channel (layout 1) audio sample packets.
- Decides the packet type for every data-island slot, with a configurable InfoFrame repeat period and an ACR starvation guard.
- Outputs the packet type plus the audio payload; the packet formatter modules downstream consume them.

Parameters:
- AUDIO_BIT_WIDTH, 24, sample width (16..24); samples are left-justified into 24 bits.
- AUDIO_CHANNELS, 2, either 2 (layout 0) or 8 (layout 1); any other value is an elaboration error.
- FIFO_DEPTH, 8, number of sample frames buffered; must be a power of two and at least 4.
- INFOFRAME_PERIOD_FIELDS, 1, each enabled InfoFrame is resent once per this many video fields (1..2).
- INFOFRAME_ENABLE, 3'b111, enable bits: bit0 audio InfoFrame (0x84), bit1 AVI (0x82), bit2 SPD (0x83).
- ACR_MAX_DEFER, 2, maximum consecutive audio grants allowed while ACR is pending.

Ports:
- clk_pixel  in  1  pixel clock.
- reset  in  1  asynchronous, active-high reset.
- video_field_end  in  1  one-cycle strobe at the end of a field.
- packet_enable  in  1  one-cycle strobe: choose the packet for the next island slot.
- audio_sample_valid  in  1  a sample frame is offered (already in the clk_pixel domain).
- audio_sample_ready  out  1  FIFO can accept a frame.
- audio_sample_word  in  AUDIO_CHANNELS x AUDIO_BIT_WIDTH  one frame, channel 0 first.
- clk_audio_counter_wrap  in  1  level that toggles once per ACR period.
- packet_type  out  8  0x00 null, 0x01 ACR, 0x02 audio sample, 0x82/0x83/0x84 InfoFrames.
- audio_layout  out  1  0 or 1, constant from AUDIO_CHANNELS.
- audio_sample_word_packet  out  4x2x24  subpacket payloads.
- audio_sample_word_present  out  4  subpacket present bits.
- audio_sample_b  out  4  IEC 60958 block-start flag per subpacket.
- audio_overflow  out  1  sticky: a frame was dropped.

Behaviour:
- Reset values:
  - packet_type = 0x00; FIFO empty; audio_sample_ready = 1.
  - Payload, present and b outputs = 0; frame_counter = 0; audio_overflow = 0.
  - All InfoFrame sent flags = 0, so every enabled InfoFrame is due at once.
  - acr_pending = 0; defer counter = 0; last_wrap captures clk_audio_counter_wrap.
- FIFO push:
  - A frame is pushed when valid && ready.
  - audio_sample_ready = !full.
  - valid while full drops the frame and sets audio_overflow; it clears only on reset.
  - A push and pop in the same cycle change the count by push count minus pop count. A frame pushed in cycle N can be popped no earlier than cycle N+1.
- ACR request: acr_pending is set when clk_audio_counter_wrap != last_wrap; last_wrap then updates. The request is cleared when ACR is granted. A toggle in the same cycle as the grant keeps acr_pending set.
- Arbitration happens on a packet_enable cycle with video_field_end low. Priority, highest first:
  - a) ACR, if acr_pending and defer counter == ACR_MAX_DEFER.
  - b) Audio sample packet, if the FIFO is non-empty.
  - c) ACR, if acr_pending.
  - d) Due InfoFrames in the order 0x84, 0x82, 0x83.
  - e) Null.
- Defer counter: increments on each audio grant while acr_pending, saturating at ACR_MAX_DEFER. It resets to 0 on an ACR grant.
- Output latency: all outputs register on the packet_enable edge and hold until the next grant.
- Audio grant, layout 0:
  - Pops n = min(count, 4) frames.
  - Subpacket i carries frame i (channels 0/1); present = (1<<n)-1.
  - Unused subpackets are zero.
- Audio grant, layout 1:
  - Pops exactly 1 frame; subpacket i carries channels 2i and 2i+1; present = 4'b1111.
  - Frame index advances by 1.
- IEC 60958 frame counter:
  - audio_sample_b[i] = 1 when the frame index (frame_counter + i) mod 192 == 0. In layout 1 only bit 0 can be 1.
  - frame_counter advances by the number of frames popped, mod 192. 188 + 4 wraps to 0.
- InfoFrame scheduling:
  - A field counter counts video_field_end pulses modulo INFOFRAME_PERIOD_FIELDS.
  - On wrap to 0, every sent flag clears.
  - An InfoFrame grant sets its flag. Disabled InfoFrames are never due.
- video_field_end with packet_enable in the same cycle: field handling is applied, no grant is made, and packet_type goes to 0x00 (never X).

Decomposition:
- hdmi_packet_pkg holds:
  - packet type localparams;
  - the layout enum;
  - a sample_frame_t typedef;
  - the function sampling_frequency_code(rate);
  - the 192-frame block-length constant.
- One sub-module, sample_frame_fifo: synchronous FIFO of width AUDIO_CHANNELS*24 with count output and multi-pop (0..4) in one cycle.

Test Plan:
- Reset, then packet_enable x4 with FIFO empty and no ACR -> types 0x84, 0x82, 0x83, then 0x00.
- Layout 0: push 6 frames, then enable -> type 0x02, present 1111, 4 frames popped; next enable -> present 0011.
- Layout 1: push 1 frame with channel k = k+1 -> subpacket 3 = {8, 7}, present 1111.
- Frame counter: start at 188, push 8 frames, two grants -> second packet has audio_sample_b = 0001 and frame_counter = 4.
- ACR starvation: acr_pending with FIFO never empty and ACR_MAX_DEFER = 2 -> grants 0x02, 0x02, 0x01.
- Fill the FIFO to 8 and push a 9th -> ready 0 and audio_overflow 1. Assert reset mid-stream -> all reset values and ready 1. video_field_end together with packet_enable -> type 0x00.

Source files
------------

// File: rtl/hdmi_packet_pkg.sv
// Shared types and constants for the HDMI data-island packet scheduler.
package hdmi_packet_pkg;

    localparam logic [7:0] PKT_NULL  = 8'h00;
    localparam logic [7:0] PKT_ACR   = 8'h01;
    localparam logic [7:0] PKT_AUDIO = 8'h02;
    localparam logic [7:0] PKT_AVI   = 8'h82;
    localparam logic [7:0] PKT_SPD   = 8'h83;
    localparam logic [7:0] PKT_AIF   = 8'h84;

    localparam int unsigned IEC_BLOCK_FRAMES = 192;

    typedef enum logic {
        LAYOUT_2CH = 1'b0,
        LAYOUT_8CH = 1'b1
    } audio_layout_e;

    // One subpacket payload: [0] = first channel, [1] = second channel, left-justified.
    typedef logic [1:0][23:0] sample_frame_t;

    // IEC 60958 channel-status sampling frequency code for a rate in Hz.
    function automatic logic [3:0] sampling_frequency_code(input int unsigned rate);
        case (rate)
            32'd32000:  return 4'b0011;
            32'd44100:  return 4'b0000;
            32'd48000:  return 4'b0010;
            32'd88200:  return 4'b1000;
            32'd96000:  return 4'b1010;
            32'd176400: return 4'b1100;
            32'd192000: return 4'b1110;
            default:    return 4'b0001;
        endcase
    endfunction

endpackage

// File: rtl/hdmi_packet_scheduler_if.sv
// Sample input, island-slot control and packet output bundle of the scheduler.
interface hdmi_packet_scheduler_if import hdmi_packet_pkg::*; #(
    parameter int unsigned AUDIO_BIT_WIDTH = 24,
    parameter int unsigned AUDIO_CHANNELS  = 2
) ();
    logic                                      video_field_end;
    logic                                      packet_enable;
    logic                                      audio_sample_valid;
    logic                                      audio_sample_ready;
    logic [AUDIO_CHANNELS*AUDIO_BIT_WIDTH-1:0] audio_sample_word;
    logic                                      clk_audio_counter_wrap;
    logic [7:0]                                packet_type;
    logic                                      audio_layout;
    sample_frame_t [3:0]                       audio_sample_word_packet;
    logic [3:0]                                audio_sample_word_present;
    logic [3:0]                                audio_sample_b;
    logic                                      audio_overflow;

    modport master (
        output video_field_end, packet_enable, audio_sample_valid, audio_sample_word,
               clk_audio_counter_wrap,
        input  audio_sample_ready, packet_type, audio_layout, audio_sample_word_packet,
               audio_sample_word_present, audio_sample_b, audio_overflow
    );

    modport slave (
        input  video_field_end, packet_enable, audio_sample_valid, audio_sample_word,
               clk_audio_counter_wrap,
        output audio_sample_ready, packet_type, audio_layout, audio_sample_word_packet,
               audio_sample_word_present, audio_sample_b, audio_overflow
    );
endinterface

// File: rtl/sample_frame_fifo.sv
// Synchronous frame FIFO with a count output and up to four pops per cycle.
module sample_frame_fifo #(
    parameter int unsigned WIDTH      = 48,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned READ_PORTS = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                push,
    input  logic [WIDTH-1:0]                    push_data,
    input  logic [2:0]                          pop_cnt,
    output logic [READ_PORTS-1:0][WIDTH-1:0]    rd_data,
    output logic [$clog2(DEPTH):0]              count,
    output logic                                full
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr <= rd_ptr + PTR_W'(pop_cnt);
            count  <= count + CNT_W'(push) - CNT_W'(pop_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // Oldest frames first; pointer arithmetic wraps because DEPTH is a power of two.
    for (genvar i = 0; i < READ_PORTS; i++) begin : g_rd
        assign rd_data[i] = mem[rd_ptr + PTR_W'(i)];
    end

    assign full = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/hdmi_packet_scheduler.sv
// Picks the packet type for each data-island slot and assembles the audio sample payload.
module hdmi_packet_scheduler import hdmi_packet_pkg::*; #(
    parameter int unsigned AUDIO_BIT_WIDTH         = 24,
    parameter int unsigned AUDIO_CHANNELS          = 2,
    parameter int unsigned FIFO_DEPTH              = 8,
    parameter int unsigned INFOFRAME_PERIOD_FIELDS = 1,
    parameter logic [2:0]  INFOFRAME_ENABLE        = 3'b111,
    parameter int unsigned ACR_MAX_DEFER           = 2
) (
    input logic               clk_pixel,
    input logic               reset,
    hdmi_packet_scheduler_if.slave bus
);
    localparam int unsigned FRAME_W    = AUDIO_CHANNELS * 24;
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned DEFER_W    = (ACR_MAX_DEFER > 0) ? $clog2(ACR_MAX_DEFER + 1) : 1;
    localparam int unsigned FIELD_W    = (INFOFRAME_PERIOD_FIELDS > 1) ? $clog2(INFOFRAME_PERIOD_FIELDS) : 1;
    localparam int unsigned READ_PORTS = (AUDIO_CHANNELS == 8) ? 1 : 4;
    localparam audio_layout_e LAYOUT   = (AUDIO_CHANNELS == 8) ? LAYOUT_8CH : LAYOUT_2CH;

    if (AUDIO_CHANNELS != 2 && AUDIO_CHANNELS != 8) begin : g_bad_channels
        $error("AUDIO_CHANNELS must be 2 or 8");
    end
    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 4");
    end

    typedef enum logic [2:0] {
        GRANT_NONE, GRANT_ACR, GRANT_AUDIO, GRANT_AIF, GRANT_AVI, GRANT_SPD
    } grant_e;

    logic [FRAME_W-1:0]                   push_frame;
    logic [READ_PORTS-1:0][FRAME_W-1:0]   rd_frames;
    logic [CNT_W-1:0]                     fifo_count;
    logic                                 fifo_full;
    logic                                 push_c;
    logic [2:0]                           pop_cnt_c;
    logic                                 last_wrap;
    logic                                 acr_pending;
    logic [DEFER_W-1:0]                   defer_cnt;
    logic [FIELD_W-1:0]                   field_cnt;
    logic [2:0]                           if_sent;
    logic [2:0]                           due_c;
    logic [7:0]                           frame_counter;
    logic [8:0]                           fsum_c;
    logic [7:0]                           frame_next_c;
    grant_e                               grant_c;
    logic [7:0]                           type_c;
    sample_frame_t [3:0]                  payload_c;
    logic [3:0]                           present_c;
    logic [3:0]                           b_c;

    // Left-justify each channel into a 24-bit slot before buffering.
    for (genvar c = 0; c < AUDIO_CHANNELS; c++) begin : g_justify
        assign push_frame[c*24 +: 24] =
            24'(bus.audio_sample_word[c*AUDIO_BIT_WIDTH +: AUDIO_BIT_WIDTH]) << (24 - AUDIO_BIT_WIDTH);
    end

    assign push_c                 = bus.audio_sample_valid & ~fifo_full;
    assign bus.audio_sample_ready = ~fifo_full;
    assign bus.audio_layout       = LAYOUT;
    assign due_c                  = INFOFRAME_ENABLE & ~if_sent;

    sample_frame_fifo #(
        .WIDTH      (FRAME_W),
        .DEPTH      (FIFO_DEPTH),
        .READ_PORTS (READ_PORTS)
    ) u_fifo (
        .clk       (clk_pixel),
        .rst       (reset),
        .push      (push_c),
        .push_data (push_frame),
        .pop_cnt   (pop_cnt_c),
        .rd_data   (rd_frames),
        .count     (fifo_count),
        .full      (fifo_full)
    );

    // Slot arbitration; a field-end strobe suppresses the grant.
    always_comb begin
        grant_c = GRANT_NONE;
        if (bus.packet_enable && !bus.video_field_end) begin
            if (acr_pending && defer_cnt == DEFER_W'(ACR_MAX_DEFER)) grant_c = GRANT_ACR;
            else if (fifo_count != '0)                               grant_c = GRANT_AUDIO;
            else if (acr_pending)                                    grant_c = GRANT_ACR;
            else if (due_c[0])                                       grant_c = GRANT_AIF;
            else if (due_c[1])                                       grant_c = GRANT_AVI;
            else if (due_c[2])                                       grant_c = GRANT_SPD;
        end
    end

    always_comb begin
        type_c = PKT_NULL;
        case (grant_c)
            GRANT_ACR:   type_c = PKT_ACR;
            GRANT_AUDIO: type_c = PKT_AUDIO;
            GRANT_AIF:   type_c = PKT_AIF;
            GRANT_AVI:   type_c = PKT_AVI;
            GRANT_SPD:   type_c = PKT_SPD;
            default:     type_c = PKT_NULL;
        endcase
    end

    always_comb begin
        pop_cnt_c = '0;
        if (grant_c == GRANT_AUDIO) begin
            if (LAYOUT == LAYOUT_8CH)           pop_cnt_c = 3'd1;
            else if (fifo_count >= CNT_W'(4))   pop_cnt_c = 3'd4;
            else                                pop_cnt_c = 3'(fifo_count);
        end
    end

    assign fsum_c       = 9'(frame_counter) + 9'(pop_cnt_c);
    assign frame_next_c = (fsum_c >= 9'(IEC_BLOCK_FRAMES)) ? 8'(fsum_c - 9'(IEC_BLOCK_FRAMES))
                                                           : 8'(fsum_c);

    if (AUDIO_CHANNELS == 8) begin : g_layout1
        // One frame spread across all four subpackets, channel pairs in order.
        always_comb begin
            payload_c = '0;
            present_c = 4'b1111;
            b_c       = '0;
            for (int i = 0; i < 4; i++) begin
                payload_c[i] = rd_frames[0][i*48 +: 48];
            end
            b_c[0] = (frame_counter == '0);
        end
    end else begin : g_layout0
        always_comb begin
            logic [8:0] idx_sum;
            idx_sum   = '0;
            payload_c = '0;
            present_c = '0;
            b_c       = '0;
            for (int i = 0; i < 4; i++) begin
                idx_sum = 9'(frame_counter) + 9'(i);
                if (3'(i) < pop_cnt_c) begin
                    payload_c[i] = rd_frames[i];
                    present_c[i] = 1'b1;
                    b_c[i]       = (idx_sum == '0) || (idx_sum == 9'(IEC_BLOCK_FRAMES));
                end
            end
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            bus.packet_type               <= PKT_NULL;
            bus.audio_sample_word_packet  <= '0;
            bus.audio_sample_word_present <= '0;
            bus.audio_sample_b            <= '0;
            bus.audio_overflow            <= 1'b0;
            frame_counter                 <= '0;
            if_sent                       <= '0;
            field_cnt                     <= '0;
            acr_pending                   <= 1'b0;
            defer_cnt                     <= '0;
            last_wrap                     <= bus.clk_audio_counter_wrap;
        end else begin
            last_wrap   <= bus.clk_audio_counter_wrap;
            acr_pending <= (bus.clk_audio_counter_wrap ^ last_wrap) |
                           (acr_pending & (grant_c != GRANT_ACR));
            frame_counter <= frame_next_c;

            if (bus.audio_sample_valid && fifo_full) bus.audio_overflow <= 1'b1;

            if (grant_c == GRANT_ACR) begin
                defer_cnt <= '0;
            end else if (grant_c == GRANT_AUDIO && acr_pending &&
                         defer_cnt != DEFER_W'(ACR_MAX_DEFER)) begin
                defer_cnt <= defer_cnt + DEFER_W'(1);
            end

            if (bus.packet_enable) begin
                bus.packet_type <= type_c;
                if (grant_c == GRANT_AUDIO) begin
                    bus.audio_sample_word_packet  <= payload_c;
                    bus.audio_sample_word_present <= present_c;
                    bus.audio_sample_b            <= b_c;
                end else begin
                    bus.audio_sample_word_packet  <= '0;
                    bus.audio_sample_word_present <= '0;
                    bus.audio_sample_b            <= '0;
                end
            end

            // Field wrap re-arms every InfoFrame; otherwise grants mark them sent.
            if (bus.video_field_end) begin
                if (field_cnt == FIELD_W'(INFOFRAME_PERIOD_FIELDS - 1)) begin
                    field_cnt <= '0;
                    if_sent   <= '0;
                end else begin
                    field_cnt <= field_cnt + FIELD_W'(1);
                end
            end else begin
                if (grant_c == GRANT_AIF) if_sent[0] <= 1'b1;
                if (grant_c == GRANT_AVI) if_sent[1] <= 1'b1;
                if (grant_c == GRANT_SPD) if_sent[2] <= 1'b1;
            end
        end
    end

endmodule
